debounce_sync: RTL and testbench

- Input conditioning stage placed directly upstream of the team's D flip-flop / register blocks.
- Takes raw asynchronous per-channel inputs (switches, external lines) and brings them into the clk domain with a multi-flop synchronizer.
- Filters glitches with a per-channel stability counter.
- Delivers clean levels plus single-cycle rise/fall pulses that the downstream DFF stages sample directly.

---
 rtl/debounce_sync.sv | 92 +++++++++
 tb/tb_debounce_sync.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/debounce_sync.sv
// debounce_sync: per-channel input conditioner.
// Raw asynchronous inputs pass through a flop-only synchronizer chain. A
// per-channel stability counter then filters glitches, and the block produces
// clean levels plus one-cycle rise/fall pulses for the downstream registers.
module debounce_sync #(
    parameter  int CH              = 4,
    parameter  int SYNC_STAGES     = 2,
    parameter  int DEBOUNCE_CYCLES = 4,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] din,
    output logic [CH-1:0] dout,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall,
    output logic          busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CH-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [CH-1:0]                  dout_q, dout_d;
    logic [CH-1:0]                  rise_q, rise_d;
    logic [CH-1:0]                  fall_q, fall_d;
    logic [CH-1:0]                  s;

    // Synchronizer chain: a pure shift, with din entering at stage 0 and the
    // last stage used as the synchronized level.
    always_comb begin
        sync_d = sync_q;
        s      = '0;
        for (int i = 0; i < CH; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], din[i]};
            s[i]      = sync_q[i][SYNC_STAGES-1];
        end
    end

    // Stability filter: dout only follows s after DEBOUNCE_CYCLES consecutive
    // edges of disagreement. Any agreement clears the count.
    always_comb begin
        cnt_d  = cnt_q;
        dout_d = dout_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < CH; i++) begin
            if (s[i] == dout_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                dout_d[i] = s[i];
                cnt_d[i]  = '0;
                rise_d[i] = s[i];
                fall_d[i] = ~s[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // State registers. Reset clears everything, so the outputs drop to 0
    // without a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    // busy: some channel is partway through a stability count.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < CH; i++) begin
            if (cnt_q[i] != '0) busy = 1'b1;
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync: directed plus random stimulus for debounce_sync, compared
// against a history-based reference. The reference keeps a log of din samples
// and flips a channel when its last DB synchronized samples all disagree with
// the current level.
module tb_debounce_sync;

    localparam int CH  = 4;
    localparam int SS  = 2;
    localparam int DB  = 4;
    localparam int LOG = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] din = 4'hF;
    logic [CH-1:0] dout, rise, fall;
    logic          busy;

    debounce_sync #(
        .CH(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk), .rst(rst), .din(din),
        .dout(dout), .rise(rise), .fall(fall), .busy(busy)
    );

    always #10 clk = ~clk;

    // reference state
    logic [CH-1:0] din_log  [0:LOG-1];
    logic [CH-1:0] samp_log [0:LOG-1];
    logic [CH-1:0] m_dout, m_rise, m_fall;
    logic          m_busy;
    int            n;
    int            checks = 0;
    int            fails  = 0;

    task automatic chk(input string tag, input logic [CH-1:0] act, input logic [CH-1:0] exp);
        checks++;
        assert (act === exp)
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_dout"}, dout, m_dout);
        chk({tag, "_rise"}, rise, m_rise);
        chk({tag, "_fall"}, fall, m_fall);
        chk({tag, "_busy"}, 4'(busy), 4'(m_busy));
    endtask

    task automatic model_clear();
        m_dout = '0;
        m_rise = '0;
        m_fall = '0;
        m_busy = 1'b0;
        n      = 0;
    endtask

    // Reference behaviour at one rising edge since reset release (index n).
    // The synchronized value seen at edge n is din as sampled SS edges earlier.
    task automatic model_edge();
        logic [CH-1:0] sp, nd;
        bit            all_diff;
        din_log[n] = din;
        sp = (n >= SS) ? din_log[n-SS] : '0;
        samp_log[n] = sp;
        nd = m_dout;
        for (int c = 0; c < CH; c++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DB; j++) begin
                if (n - j < 0) all_diff = 1'b0;
                else if (samp_log[n-j][c] == m_dout[c]) all_diff = 1'b0;
            end
            if (all_diff) nd[c] = ~m_dout[c];
        end
        m_rise = nd & ~m_dout;
        m_fall = ~nd & m_dout;
        m_dout = nd;
        // a count is pending when the latest synchronized value still differs
        m_busy = |(sp ^ nd);
        n++;
    endtask

    task automatic step(input logic [CH-1:0] v);
        din = v;
        @(posedge clk);
        model_edge();
        #1;
        check_all("step");
    endtask

    // Assert reset between edges, check outputs clear at once, hold for cyc
    // edges, then release on a falling edge.
    task automatic reset_hold(input int cyc);
        rst = 1'b1;
        #1;
        model_clear();
        check_all("rst_async");
        repeat (cyc) begin
            @(posedge clk);
            #1;
            check_all("rst_hold");
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [CH-1:0] v;
        model_clear();

        // reset with all inputs high, then hold high: first dout on 6th edge
        reset_hold(3);
        for (int e = 1; e <= 8; e++) begin
            step(4'hF);
            chk("rst_first_dout", dout, (e >= 6) ? 4'hF : 4'h0);
        end
        for (int e = 0; e < 8; e++) step(4'h0);

        // clean single-channel edge
        for (int e = 1; e <= 10; e++) begin
            step(4'h1);
            chk("clean_dout0", 4'(dout[0]), 4'(e >= 6));
            chk("clean_rise0", 4'(rise[0]), 4'(e == 6));
            chk("clean_fall", fall, 4'h0);
        end
        for (int e = 0; e < 8; e++) step(4'h0);

        // 2-cycle glitch on channel 1
        step(4'h2);
        step(4'h2);
        for (int e = 0; e < 8; e++) begin
            step(4'h0);
            chk("glitch_rise1", 4'(rise[1]), 4'h0);
        end

        // exactly DB cycles high on channel 2
        for (int e = 0; e < 4; e++) step(4'h4);
        for (int e = 0; e < 10; e++) step(4'h0);

        // simultaneous change on channels 1 and 3
        for (int e = 1; e <= 8; e++) begin
            step(4'hA);
            chk("simul_rise", rise, (e == 6) ? 4'hA : 4'h0);
        end
        for (int e = 1; e <= 8; e++) begin
            step(4'h0);
            chk("simul_fall", fall, (e == 6) ? 4'hA : 4'h0);
        end

        // reset in the middle of a count on channel 3
        for (int e = 0; e < 3; e++) step(4'h8);
        reset_hold(2);
        for (int e = 1; e <= 8; e++) begin
            step(4'h8);
            chk("midrst_dout3", 4'(dout[3]), 4'(e >= 6));
        end
        for (int e = 0; e < 8; e++) step(4'h0);

        // random toggling with short and long holds, occasional reset
        v = '0;
        for (int k = 0; k < 600; k++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 4) == 0) v[c] = ~v[c];
            if ($urandom_range(0, 149) == 0) begin
                din = v;
                reset_hold(1);
            end
            step(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
